uart_word_packer: RTL and testbench

Collects the byte stream from the UART receiver and packs every BYTES_PER_WORD bytes into one memory word. Drives a single-port block-RAM write interface with word-accurate addressing. Supports wrap or stop-when-full buffering and flushes partial words after an inter-byte timeout. Sits between uart_rx and the block RAM as the parametrised successor of the fixed 4-byte/16-deep packing logic.

---
 rtl/uart_word_packer_if.sv | 23 ++
 rtl/uart_word_packer.sv | 187 ++++++++++++++++++
 tb/tb_uart_word_packer.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_packer_if.sv
// uart_word_packer bus bundle: received byte stream in, RAM write port out.
// master = byte source / RAM side, slave = packer side.
interface uart_word_packer_if #(
  parameter int BYTE_WIDTH = 8,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_W     = 4
);
  logic [BYTE_WIDTH-1:0] i_byte;
  logic                  i_byte_valid;
  logic                  o_wr_en;
  logic [ADDR_W-1:0]     o_wr_addr;
  logic [WORD_WIDTH-1:0] o_wr_data;

  modport master (
    output i_byte, i_byte_valid,
    input  o_wr_en, o_wr_addr, o_wr_data
  );

  modport slave (
    input  i_byte, i_byte_valid,
    output o_wr_en, o_wr_addr, o_wr_data
  );
endinterface

// File: rtl/uart_word_packer.sv
// uart_word_packer: packs UART bytes into RAM words with timeout flush.
// Optional running XOR of written words: UART_WORD_PACKER_CHECKSUM_EN.
module uart_word_packer #(
  parameter int BYTE_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int DEPTH          = 16,
  parameter int MSB_FIRST      = 1,
  parameter int WRAP_MODE      = 1,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int PAD_PARTIAL    = 1,
  localparam int WORD_WIDTH = BYTE_WIDTH * BYTES_PER_WORD,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_clear,
  uart_word_packer_if.slave bus,
  output logic [CW-1:0] o_word_count,
  output logic          o_full,
  output logic          o_overflow,
  output logic          o_wrap,
`ifdef UART_WORD_PACKER_CHECKSUM_EN
  output logic [WORD_WIDTH-1:0] o_checksum,
`endif
  output logic          o_timeout
);

  localparam int CNT_W = (BYTES_PER_WORD > 1) ?
                         $clog2(BYTES_PER_WORD) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] ATOP = ADDR_W'(DEPTH - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] asm_q, asm_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [CW-1:0]         wcount_q, wcount_d;
  logic                  ovf_q, ovf_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [WORD_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wrap_q, wrap_d;
  logic                  to_q, to_d;

  logic                  accept;
  logic                  hit;
  logic                  do_wr;
  logic [WORD_WIDTH-1:0] word;
  logic [CNT_W-1:0]      lane;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      asm_q     <= '0;
      timer_q   <= '0;
      addr_q    <= '0;
      wcount_q  <= '0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wrap_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      timer_q   <= timer_d;
      addr_q    <= addr_d;
      wcount_q  <= wcount_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wrap_q    <= wrap_d;
      to_q      <= to_d;
    end
  end

  // Byte accept, word completion, timeout flush and address advance
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    timer_d   = timer_q;
    addr_d    = addr_q;
    wcount_d  = wcount_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wrap_d    = 1'b0;
    to_d      = 1'b0;
    do_wr     = 1'b0;
    word      = asm_q;
    lane      = (MSB_FIRST != 0) ? LAST - cnt_q : cnt_q;
    accept    = bus.i_byte_valid && (state_q != FULL) && !i_clear;
    hit       = (TIMEOUT_CYCLES > 0) && (state_q == COLLECT) &&
                (timer_q == TMAX);

    if (i_clear) begin
      state_d  = IDLE;
      cnt_d    = '0;
      asm_d    = '0;
      timer_d  = '0;
      addr_d   = '0;
      wcount_d = '0;
      ovf_d    = 1'b0;
    end else if (accept) begin
      word[lane*BYTE_WIDTH +: BYTE_WIDTH] = bus.i_byte;
      timer_d = '0;
      if (cnt_q == LAST) begin
        do_wr   = 1'b1;
        cnt_d   = '0;
        asm_d   = '0;
        state_d = IDLE;
      end else begin
        asm_d   = word;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = COLLECT;
      end
    end else if (state_q == FULL) begin
      if (bus.i_byte_valid) ovf_d = 1'b1;
    end else if (hit) begin
      to_d    = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
      asm_d   = '0;
      timer_d = '0;
      do_wr   = (PAD_PARTIAL != 0);
    end else if (state_q == COLLECT && TIMEOUT_CYCLES > 0) begin
      timer_d = timer_q + TW'(1);
    end

    if (do_wr) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = word;
      if (wcount_q != CMAX) wcount_d = wcount_q + CW'(1);
      if (addr_q == ATOP) begin
        addr_d = '0;
        if (WRAP_MODE != 0) wrap_d = 1'b1;
        else state_d = FULL;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

`ifdef UART_WORD_PACKER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] csum_q;

  // Running XOR of every word written to the RAM
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) csum_q <= '0;
    else if (i_clear) csum_q <= '0;
    else if (wr_en_q) csum_q <= csum_q ^ wr_data_q;
  end

  assign o_checksum = csum_q;
`endif

  assign bus.o_wr_en   = wr_en_q;
  assign bus.o_wr_addr = wr_addr_q;
  assign bus.o_wr_data = wr_data_q;
  assign o_word_count  = wcount_q;
  assign o_full        = (state_q == FULL);
  assign o_overflow    = ovf_q;
  assign o_wrap        = wrap_q;
  assign o_timeout     = to_q;

endmodule

// File: tb/tb_uart_word_packer.sv
// tb_uart_word_packer: directed scoreboard bench over six configurations.
// Expected writes are queued when bytes are driven, popped on o_wr_en.
module tb_uart_word_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] byte_v = '0;
  logic       val = 1'b0;
  int         sel = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wrap;
  } exp_t;

  exp_t sbq[$];

  uart_word_packer_if #(8, 32, 4) if0 ();
  uart_word_packer_if #(8, 32, 4) if1 ();
  uart_word_packer_if #(8, 32, 2) if2 ();
  uart_word_packer_if #(8, 32, 4) if3 ();
  uart_word_packer_if #(8, 32, 4) if4 ();
  uart_word_packer_if #(8, 8, 2)  if5 ();

  assign if0.i_byte = byte_v;
  assign if1.i_byte = byte_v;
  assign if2.i_byte = byte_v;
  assign if3.i_byte = byte_v;
  assign if4.i_byte = byte_v;
  assign if5.i_byte = byte_v;
  assign if0.i_byte_valid = val && sel == 0;
  assign if1.i_byte_valid = val && sel == 1;
  assign if2.i_byte_valid = val && sel == 2;
  assign if3.i_byte_valid = val && sel == 3;
  assign if4.i_byte_valid = val && sel == 4;
  assign if5.i_byte_valid = val && sel == 5;

  logic [4:0] wc0, wc1, wc3, wc4;
  logic [2:0] wc2, wc5;
  logic [5:0] fl, ov, wr, to;
`ifdef UART_WORD_PACKER_CHECKSUM_EN
  logic [31:0] cs0, cs1, cs2, cs3, cs4;
  logic [7:0]  cs5;
`endif

  uart_word_packer u0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr), .bus(if0),
    .o_word_count(wc0), .o_full(fl[0]), .o_overflow(ov[0]),
    .o_wrap(wr[0]),
`ifdef UART_WORD_PACKER_CHECKSUM_EN
    .o_checksum(cs0),
`endif
    .o_timeout(to[0]));

  uart_word_packer #(.MSB_FIRST(0)) u1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr), .bus(if1),
    .o_word_count(wc1), .o_full(fl[1]), .o_overflow(ov[1]),
    .o_wrap(wr[1]),
`ifdef UART_WORD_PACKER_CHECKSUM_EN
    .o_checksum(cs1),
`endif
    .o_timeout(to[1]));

  uart_word_packer #(.DEPTH(4), .WRAP_MODE(0)) u2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr), .bus(if2),
    .o_word_count(wc2), .o_full(fl[2]), .o_overflow(ov[2]),
    .o_wrap(wr[2]),
`ifdef UART_WORD_PACKER_CHECKSUM_EN
    .o_checksum(cs2),
`endif
    .o_timeout(to[2]));

  uart_word_packer #(.TIMEOUT_CYCLES(100)) u3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr), .bus(if3),
    .o_word_count(wc3), .o_full(fl[3]), .o_overflow(ov[3]),
    .o_wrap(wr[3]),
`ifdef UART_WORD_PACKER_CHECKSUM_EN
    .o_checksum(cs3),
`endif
    .o_timeout(to[3]));

  uart_word_packer #(.TIMEOUT_CYCLES(100), .PAD_PARTIAL(0)) u4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr), .bus(if4),
    .o_word_count(wc4), .o_full(fl[4]), .o_overflow(ov[4]),
    .o_wrap(wr[4]),
`ifdef UART_WORD_PACKER_CHECKSUM_EN
    .o_checksum(cs4),
`endif
    .o_timeout(to[4]));

  uart_word_packer #(.BYTES_PER_WORD(1), .DEPTH(4)) u5 (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr), .bus(if5),
    .o_word_count(wc5), .o_full(fl[5]), .o_overflow(ov[5]),
    .o_wrap(wr[5]),
`ifdef UART_WORD_PACKER_CHECKSUM_EN
    .o_checksum(cs5),
`endif
    .o_timeout(to[5]));

  logic        wen_m, wrap_m, to_m;
  logic [31:0] addr_m, data_m;

  always_comb begin
    wen_m  = 1'b0;
    addr_m = '0;
    data_m = '0;
    case (sel)
      0: begin
        wen_m = if0.o_wr_en;
        addr_m = 32'(if0.o_wr_addr);
        data_m = if0.o_wr_data;
      end
      1: begin
        wen_m = if1.o_wr_en;
        addr_m = 32'(if1.o_wr_addr);
        data_m = if1.o_wr_data;
      end
      2: begin
        wen_m = if2.o_wr_en;
        addr_m = 32'(if2.o_wr_addr);
        data_m = if2.o_wr_data;
      end
      3: begin
        wen_m = if3.o_wr_en;
        addr_m = 32'(if3.o_wr_addr);
        data_m = if3.o_wr_data;
      end
      4: begin
        wen_m = if4.o_wr_en;
        addr_m = 32'(if4.o_wr_addr);
        data_m = if4.o_wr_data;
      end
      default: begin
        wen_m = if5.o_wr_en;
        addr_m = 32'(if5.o_wr_addr);
        data_m = 32'(if5.o_wr_data);
      end
    endcase
  end

  assign wrap_m = wr[sel];
  assign to_m   = to[sel];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every write of the selected DUT
  always @(negedge clk) begin
    if (rst_n && wen_m) begin
      if (sbq.size() == 0) begin
        chk("unexpected_write", {32'(sel), addr_m}, 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("wr_addr", 64'(addr_m), 64'(e.addr));
        chk("wr_data", 64'(data_m), 64'(e.data));
        chk("wr_wrap", 64'(wrap_m), 64'(e.wrap));
      end
    end
  end

  task automatic expect_wr(input logic [31:0] a,
                           input logic [31:0] d,
                           input logic w);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.wrap = w;
    sbq.push_back(e);
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    byte_v = b;
    val = 1'b1;
  endtask

  task automatic stop();
    @(negedge clk);
    val = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] w);
    for (int j = 3; j >= 0; j--) put(w[j*8 +: 8]);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain", 64'(sbq.size()), 64'd0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic timeout_run(input int k,
                             output int n,
                             output logic w);
    @(negedge clk);
    sel = k;
    byte_v = 8'hAA;
    val = 1'b1;
    @(negedge clk);
    byte_v = 8'hBB;
    @(posedge clk);
    @(negedge clk);
    val = 1'b0;
    n = 0;
    w = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (to_m) begin
        w = wen_m;
        break;
      end
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic w;

    repeat (3) @(negedge clk);
    chk("rst_wr_en", 64'(if0.o_wr_en), 64'd0);
    chk("rst_addr", 64'(if0.o_wr_addr), 64'd0);
    chk("rst_data", 64'(if0.o_wr_data), 64'd0);
    chk("rst_count", 64'(wc0), 64'd0);
    chk("rst_flags", 64'({fl, ov, wr, to}), 64'd0);
    rst_n = 1'b1;

    sel = 0;
    expect_wr(0, 32'hDEADBEEF, 0);
    put_word(32'hDEADBEEF);
    @(posedge clk);
    #1;
    chk("wr_latency", 64'(wen_m), 64'd1);
    expect_wr(1, 32'h01020304, 0);
    put_word(32'h01020304);
    stop();
    drain();
    chk("count_2", 64'(wc0), 64'd2);
`ifdef UART_WORD_PACKER_CHECKSUM_EN
    chk("checksum", 64'(cs0), 64'hDFAFBDEB);
`endif

    pulse_clear();
    chk("clr_count", 64'(wc0), 64'd0);
    for (int i = 0; i < 17; i++) begin
      logic [31:0] d;
      d = 32'h1000_0000 + 32'(i * 32'h0101_0101);
      expect_wr(32'(i % 16), d, i == 15);
      put_word(d);
    end
    stop();
    drain();
    chk("wrap_count_sat", 64'(wc0), 64'd16);

    put(8'h77);
    put(8'h66);
    stop();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_wr(0, 32'h11223344, 0);
    put_word(32'h11223344);
    stop();
    drain();
    chk("rst_mid_count", 64'(wc0), 64'd1);

    put(8'hAA);
    put(8'hBB);
    put(8'hCC);
    @(negedge clk);
    byte_v = 8'hDD;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    val = 1'b0;
    expect_wr(0, 32'h10203040, 0);
    put_word(32'h10203040);
    stop();
    drain();
    chk("clr_byte_count", 64'(wc0), 64'd1);

    sel = 1;
    expect_wr(0, 32'hEFBEADDE, 0);
    put_word(32'hDEADBEEF);
    stop();
    drain();

    sel = 2;
    for (int i = 0; i < 4; i++) begin
      expect_wr(32'(i), 32'hA0A1A2A3 + 32'(i), 0);
      put_word(32'hA0A1A2A3 + 32'(i));
    end
    stop();
    drain();
    chk("full_set", 64'(fl[2]), 64'd1);
    chk("ovf_before", 64'(ov[2]), 64'd0);
    put_word(32'h55555555);
    stop();
    repeat (4) @(negedge clk);
    chk("ovf_set", 64'(ov[2]), 64'd1);
    chk("full_hold", 64'(fl[2]), 64'd1);
    chk("full_count", 64'(wc2), 64'd4);
    pulse_clear();
    chk("clr_full", 64'(fl[2]), 64'd0);
    chk("clr_ovf", 64'(ov[2]), 64'd0);
    chk("clr_count2", 64'(wc2), 64'd0);

    expect_wr(0, 32'hAABB0000, 0);
    timeout_run(3, n, w);
    chk("to_pad_latency", 64'(n), 64'd100);
    chk("to_pad_write", 64'(w), 64'd1);
    drain();

    timeout_run(4, n, w);
    chk("to_drop_latency", 64'(n), 64'd100);
    chk("to_drop_nowrite", 64'(w), 64'd0);
    repeat (5) @(negedge clk);
    chk("to_drop_count", 64'(wc4), 64'd0);

    sel = 5;
    expect_wr(0, 32'h5A, 0);
    expect_wr(1, 32'hA5, 0);
    expect_wr(2, 32'h3C, 0);
    put(8'h5A);
    put(8'hA5);
    put(8'h3C);
    stop();
    drain();
    chk("bpw1_count", 64'(wc5), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
